// File: rtl/invaders_fleet_pkg.sv
// Shared geometry, state encodings and helpers for the invader fleet.
package invaders_fleet_pkg;

    localparam int unsigned CELLS       = 20;
    localparam int unsigned CELL_W_LOG2 = 5;
    localparam int unsigned ROW_H_LOG2  = 4;
    localparam int unsigned LINE_W      = 5;
    localparam int unsigned COORD_W     = 10;
    localparam int unsigned PERIOD_W    = 23;
    localparam int unsigned COL_W       = COORD_W - CELL_W_LOG2;
    localparam int unsigned ROW_W       = COORD_W - ROW_H_LOG2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARCH = 2'd1,
        ST_WON   = 2'd2,
        ST_LOST  = 2'd3
    } fleet_state_t;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } fleet_dir_t;

    // Shorten the march period by dec, never dropping below floor and never wrapping.
    function automatic logic [PERIOD_W-1:0] sped_up_period(
        input logic [PERIOD_W-1:0] cur,
        input logic [PERIOD_W-1:0] dec,
        input logic [PERIOD_W-1:0] floor
    );
        logic [PERIOD_W:0] w_limit;
        w_limit = {1'b0, floor} + {1'b0, dec};
        if ({1'b0, cur} >= w_limit) begin
            return cur - dec;
        end
        return floor;
    endfunction

endpackage

// File: rtl/invaders_fleet_if.sv
// Game-control, bullet and fleet-status signals between the fleet and its neighbours.
interface invaders_fleet_if;
    import invaders_fleet_pkg::*;

    logic                 clear;
    logic                 start;
    logic                 enable;
    logic [COORD_W-1:0]   bullet_x;
    logic [COORD_W-1:0]   bullet_y;
    logic                 bullet_flying;
    logic [CELLS-1:0]     invaders_array;
    logic [LINE_W-1:0]    invaders_line;
    logic                 hit;
    logic                 all_dead;
    logic                 reached_bottom;

    modport master (
        output clear, start, enable, bullet_x, bullet_y, bullet_flying,
        input  invaders_array, invaders_line, hit, all_dead, reached_bottom
    );

    modport slave (
        input  clear, start, enable, bullet_x, bullet_y, bullet_flying,
        output invaders_array, invaders_line, hit, all_dead, reached_bottom
    );

endinterface

// File: rtl/invaders_fleet_step_timer.sv
// March-period timer: pulses step_tick once every period running cycles.
module fleet_step_timer
    import invaders_fleet_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] INIT_PERIOD = 23'd6_000_000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clear,
    input  logic                run,
    input  logic [PERIOD_W-1:0] period,
    output logic                step_tick
);

    logic [PERIOD_W-1:0] r_count;
    logic [PERIOD_W-1:0] r_period;
    logic                w_wrap;

    // A new period is only adopted at a wrap so a running interval is never cut short.
    assign w_wrap    = run && (r_count == (r_period - PERIOD_W'(1)));
    assign step_tick = w_wrap;

    // Counter and active-period registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count  <= '0;
            r_period <= INIT_PERIOD;
        end else if (clear) begin
            r_count  <= '0;
            r_period <= INIT_PERIOD;
        end else if (run) begin
            if (w_wrap) begin
                r_count  <= '0;
                r_period <= period;
            end else begin
                r_count  <= r_count + PERIOD_W'(1);
            end
        end
    end

endmodule

// File: rtl/invaders_fleet.sv
// Invader fleet: marches, descends at the screen edges, takes bullet hits, reports win/lose.
module invaders_fleet
    import invaders_fleet_pkg::*;
#(
    parameter logic [CELLS-1:0]    INIT_ARRAY  = 20'b00101010101010101010,
    parameter logic [LINE_W-1:0]   INIT_LINE   = 5'd4,
    parameter logic [LINE_W-1:0]   BOTTOM_LINE = 5'd24,
    parameter logic [PERIOD_W-1:0] STEP_TICKS  = 23'd6_000_000,
    parameter logic [PERIOD_W-1:0] STEP_DEC    = 23'd400_000,
    parameter logic [PERIOD_W-1:0] STEP_MIN    = 23'd600_000
) (
    input  logic             clk,
    input  logic             reset,
    invaders_fleet_if.slave  bus
);

    fleet_state_t        r_state, w_state_nxt;
    fleet_dir_t          r_dir, w_dir_nxt;
    logic [CELLS-1:0]    r_array, w_array_nxt;
    logic [LINE_W-1:0]   r_line, w_line_nxt;
    logic [PERIOD_W-1:0] r_period, w_period_nxt;
    logic                r_lock, w_lock_nxt;
    logic                r_hit, w_hit_nxt;
    logic                r_all_dead;
    logic                r_reached_bottom;

    logic                w_run;
    logic                w_step_tick;
    logic [COL_W-1:0]    w_col;
    logic [ROW_W-1:0]    w_row;
    logic                w_col_ok;
    logic                w_cell_live;
    logic                w_hit_now;
    logic [CELLS-1:0]    w_kill_array;
    logic                w_unused_bits;

    assign w_run = (r_state == ST_MARCH) && bus.enable;

    fleet_step_timer #(
        .INIT_PERIOD (STEP_TICKS)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (bus.clear),
        .run       (w_run),
        .period    (r_period),
        .step_tick (w_step_tick)
    );

    // Bullet-to-cell mapping; sub-cell pixel bits do not matter.
    assign w_col         = bus.bullet_x[COORD_W-1:CELL_W_LOG2];
    assign w_row         = bus.bullet_y[COORD_W-1:ROW_H_LOG2];
    assign w_unused_bits = ^{bus.bullet_x[CELL_W_LOG2-1:0], bus.bullet_y[ROW_H_LOG2-1:0]};
    assign w_col_ok      = (w_col < COL_W'(CELLS));
    assign w_cell_live   = w_col_ok && r_array[w_col];
    assign w_hit_now     = (r_state == ST_MARCH) && bus.bullet_flying && !r_lock
                           && (w_row == ROW_W'(r_line)) && w_cell_live;
    assign w_kill_array  = w_hit_now ? (r_array & ~(CELLS'(1) << w_col)) : r_array;

    // Next-state: kill first, then step the surviving fleet; clear overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_dir_nxt    = r_dir;
        w_array_nxt  = r_array;
        w_line_nxt   = r_line;
        w_period_nxt = r_period;
        w_lock_nxt   = r_lock && bus.bullet_flying;
        w_hit_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = ST_MARCH;
                end
            end
            ST_MARCH: begin
                w_array_nxt = w_kill_array;
                if (w_hit_now) begin
                    w_hit_nxt    = 1'b1;
                    w_lock_nxt   = 1'b1;
                    w_period_nxt = sped_up_period(r_period, STEP_DEC, STEP_MIN);
                end
                if (w_step_tick) begin
                    if (r_dir == DIR_RIGHT) begin
                        if (!w_kill_array[CELLS-1]) begin
                            w_array_nxt = w_kill_array << 1;
                        end else begin
                            w_line_nxt = r_line + LINE_W'(1);
                            w_dir_nxt  = DIR_LEFT;
                        end
                    end else begin
                        if (!w_kill_array[0]) begin
                            w_array_nxt = w_kill_array >> 1;
                        end else begin
                            w_line_nxt = r_line + LINE_W'(1);
                            w_dir_nxt  = DIR_RIGHT;
                        end
                    end
                end
                if (w_kill_array == '0) begin
                    w_state_nxt = ST_WON;
                end else if (w_line_nxt == BOTTOM_LINE) begin
                    w_state_nxt = ST_LOST;
                end
            end
            default: ;
        endcase

        if (bus.clear) begin
            w_state_nxt  = ST_IDLE;
            w_dir_nxt    = DIR_RIGHT;
            w_array_nxt  = INIT_ARRAY;
            w_line_nxt   = INIT_LINE;
            w_period_nxt = STEP_TICKS;
            w_lock_nxt   = 1'b0;
            w_hit_nxt    = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_dir            <= DIR_RIGHT;
            r_array          <= INIT_ARRAY;
            r_line           <= INIT_LINE;
            r_period         <= STEP_TICKS;
            r_lock           <= 1'b0;
            r_hit            <= 1'b0;
            r_all_dead       <= 1'b0;
            r_reached_bottom <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_dir            <= w_dir_nxt;
            r_array          <= w_array_nxt;
            r_line           <= w_line_nxt;
            r_period         <= w_period_nxt;
            r_lock           <= w_lock_nxt;
            r_hit            <= w_hit_nxt;
            r_all_dead       <= (w_state_nxt == ST_WON);
            r_reached_bottom <= (w_state_nxt == ST_LOST);
        end
    end

    assign bus.invaders_array = r_array;
    assign bus.invaders_line  = r_line;
    assign bus.hit            = r_hit;
    assign bus.all_dead       = r_all_dead;
    assign bus.reached_bottom = r_reached_bottom;

endmodule

// File: tb/tb_invaders_fleet.sv
// Scoreboard bench for invaders_fleet: every change of the fleet outputs is one event,
// compared in order against hand-computed expectations (plus cycle gap where fixed).
module tb_invaders_fleet;

    typedef struct packed {
        logic [19:0] arr;
        logic [4:0]  line;
        logic        hit;
        logic        dead;
        logic        bot;
    } snap_t;

    typedef struct {
        snap_t s;
        int    gap;
    } exp_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_cmp;
    int   n_bad;
    exp_t q_a[$];
    exp_t q_b[$];

    invaders_fleet_if a_if();
    invaders_fleet_if b_if();

    invaders_fleet #(
        .STEP_TICKS (23'd10),
        .STEP_DEC   (23'd2),
        .STEP_MIN   (23'd4)
    ) u_dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (a_if)
    );

    invaders_fleet #(
        .INIT_ARRAY (20'h80001),
        .INIT_LINE  (5'd22),
        .STEP_TICKS (23'd10),
        .STEP_DEC   (23'd2),
        .STEP_MIN   (23'd4)
    ) u_dut_b (
        .clk   (clk),
        .reset (rst_b),
        .bus   (b_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int which, input logic [19:0] arr, input logic [4:0] line,
                        input logic h, input logic d, input logic b, input int gap);
        exp_t e;
        e.s   = '{arr: arr, line: line, hit: h, dead: d, bot: b};
        e.gap = gap;
        if (which == 0) q_a.push_back(e);
        else            q_b.push_back(e);
    endtask

    task automatic check_event(input int which, input snap_t act, input int gap);
        exp_t  e;
        string name;
        name = (which == 0) ? "fleet_a" : "fleet_b";
        n_cmp++;
        if ((which == 0 && q_a.size() == 0) || (which != 0 && q_b.size() == 0)) begin
            n_bad++;
            $display("FAIL %s unexpected_event: got arr=%05h line=%0d hit=%0b dead=%0b bot=%0b, required no change",
                     name, act.arr, act.line, act.hit, act.dead, act.bot);
            return;
        end
        e = (which == 0) ? q_a.pop_front() : q_b.pop_front();
        if (act != e.s || (e.gap != 0 && gap != e.gap)) begin
            n_bad++;
            $display("FAIL %s event: got arr=%05h line=%0d hit=%0b dead=%0b bot=%0b gap=%0d, required arr=%05h line=%0d hit=%0b dead=%0b bot=%0b gap=%0d",
                     name, act.arr, act.line, act.hit, act.dead, act.bot, gap,
                     e.s.arr, e.s.line, e.s.hit, e.s.dead, e.s.bot, e.gap);
        end
    endtask

    // Monitor for fleet A: any output change is an event.
    initial begin : mon_a
        snap_t cur, prev;
        int    cnt, last;
        bit    seen;
        cnt = 0; last = 0; seen = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cnt++;
            cur = '{arr: a_if.invaders_array, line: a_if.invaders_line, hit: a_if.hit,
                    dead: a_if.all_dead, bot: a_if.reached_bottom};
            if (!seen || cur != prev) begin
                check_event(0, cur, cnt - last);
                last = cnt;
                prev = cur;
                seen = 1'b1;
            end
        end
    end

    // Monitor for fleet B.
    initial begin : mon_b
        snap_t cur, prev;
        int    cnt, last;
        bit    seen;
        cnt = 0; last = 0; seen = 1'b0; prev = '0;
        forever begin
            @(negedge clk);
            cnt++;
            cur = '{arr: b_if.invaders_array, line: b_if.invaders_line, hit: b_if.hit,
                    dead: b_if.all_dead, bot: b_if.reached_bottom};
            if (!seen || cur != prev) begin
                check_event(1, cur, cnt - last);
                last = cnt;
                prev = cur;
                seen = 1'b1;
            end
        end
    end

    initial begin : stim
        n_cmp = 0;
        n_bad = 0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        a_if.clear = 1'b0; a_if.start = 1'b0; a_if.enable = 1'b1;
        a_if.bullet_x = '0; a_if.bullet_y = '0; a_if.bullet_flying = 1'b0;
        b_if.clear = 1'b0; b_if.start = 1'b0; b_if.enable = 1'b1;
        b_if.bullet_x = '0; b_if.bullet_y = '0; b_if.bullet_flying = 1'b0;
        push(0, 20'h2AAAA, 5'd4, 1'b0, 1'b0, 1'b0, 0);
        push(1, 20'h80001, 5'd22, 1'b0, 1'b0, 1'b0, 0);
        cyc(3);
        rst_a = 1'b0;
        rst_b = 1'b0;
        cyc(5);

        // Fleet A: bullet parked on a live cell while IDLE must not kill.
        a_if.bullet_x = 10'd40; a_if.bullet_y = 10'd70; a_if.bullet_flying = 1'b1;
        cyc(3);
        a_if.start = 1'b1;
        cyc(1);
        a_if.start = 1'b0;
        // first MARCH cycle kills cell 1; period 10 -> 8 from the second step on
        push(0, 20'h2AAA8, 5'd4, 1'b1, 1'b0, 1'b0, 0);
        push(0, 20'h2AAA8, 5'd4, 1'b0, 1'b0, 1'b0, 1);
        push(0, 20'h55550, 5'd4, 1'b0, 1'b0, 1'b0, 8);
        push(0, 20'hAAAA0, 5'd4, 1'b0, 1'b0, 1'b0, 8);
        push(0, 20'hAAAA0, 5'd5, 1'b0, 1'b0, 1'b0, 8);
        push(0, 20'h55550, 5'd5, 1'b0, 1'b0, 1'b0, 8);
        cyc(2);
        a_if.bullet_x = 10'd100;               // held bullet moved onto live cell 3
        cyc(33);
        a_if.bullet_flying = 1'b0;             // bullet gone: unlocks
        cyc(1);
        a_if.bullet_x = 10'd130; a_if.bullet_y = 10'd85; a_if.bullet_flying = 1'b1;
        push(0, 20'h55540, 5'd5, 1'b1, 1'b0, 1'b0, 3);
        push(0, 20'h55540, 5'd5, 1'b0, 1'b0, 1'b0, 1);
        push(0, 20'h2AAA0, 5'd5, 1'b0, 1'b0, 1'b0, 4);
        push(0, 20'h15550, 5'd5, 1'b0, 1'b0, 1'b0, 6);
        cyc(13);
        a_if.bullet_flying = 1'b0;
        rst_a = 1'b1;                          // asynchronous reset mid-MARCH
        push(0, 20'h2AAAA, 5'd4, 1'b0, 1'b0, 1'b0, 0);
        cyc(2);
        rst_a = 1'b0;
        cyc(15);

        // Fleet B: two descents reach the bottom, with a 5-cycle enable freeze between.
        b_if.start = 1'b1;
        cyc(1);
        b_if.start = 1'b0;
        push(1, 20'h80001, 5'd23, 1'b0, 1'b0, 1'b0, 0);
        push(1, 20'h80001, 5'd24, 1'b0, 1'b0, 1'b1, 15);
        cyc(12);
        b_if.enable = 1'b0;
        cyc(5);
        b_if.enable = 1'b1;
        cyc(30);
        b_if.clear = 1'b1;
        push(1, 20'h80001, 5'd22, 1'b0, 1'b0, 1'b0, 0);
        cyc(1);
        b_if.clear = 1'b0;
        cyc(3);

        // Fleet B: kill cell 0, then the last invader on the very cycle of a step.
        b_if.bullet_x = 10'd5; b_if.bullet_y = 10'd355; b_if.bullet_flying = 1'b1;
        b_if.start = 1'b1;
        cyc(1);
        b_if.start = 1'b0;
        push(1, 20'h80000, 5'd22, 1'b1, 1'b0, 1'b0, 0);
        push(1, 20'h80000, 5'd22, 1'b0, 1'b0, 1'b0, 1);
        push(1, 20'h80000, 5'd23, 1'b0, 1'b0, 1'b0, 8);
        push(1, 20'h00000, 5'd23, 1'b1, 1'b1, 1'b0, 8);
        push(1, 20'h00000, 5'd23, 1'b0, 1'b1, 1'b0, 1);
        cyc(2);
        b_if.bullet_flying = 1'b0;
        cyc(2);
        b_if.bullet_x = 10'd1023; b_if.bullet_flying = 1'b1;   // column 31: off the grid
        cyc(2);
        b_if.bullet_flying = 1'b0;
        cyc(11);
        b_if.bullet_x = 10'd620; b_if.bullet_y = 10'd370; b_if.bullet_flying = 1'b1;
        cyc(1);
        b_if.bullet_flying = 1'b0;
        cyc(20);

        // Every expected event must have been seen.
        while (q_a.size() != 0) begin
            exp_t e;
            e = q_a.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL fleet_a missing_event: got nothing, required arr=%05h line=%0d", e.s.arr, e.s.line);
        end
        while (q_b.size() != 0) begin
            exp_t e;
            e = q_b.pop_front();
            n_cmp++;
            n_bad++;
            $display("FAIL fleet_b missing_event: got nothing, required arr=%05h line=%0d", e.s.arr, e.s.line);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
